// File: rtl/aes_pkg.sv
// Shared AES types, constants and helpers for the key schedule and cipher paths.
package aes_pkg;

  localparam int KEY_W = 128;

  typedef logic [31:0]      aes_word_t;
  typedef logic [KEY_W-1:0] aes_key_t;

  typedef enum logic {IDLE, RUN} state_t;

  // Round constants, indexed by the round whose key is being stepped from.
  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // RotWord: cyclic left rotation by one byte, most significant byte first.
  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  // Table lookup.
  always_comb y = SBOX[x];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 inverse key expansion: takes the round-10 key and
// streams round keys 10 down to 0 over a valid/ready handshake.
// Optional macro AES_INV_KEY_STORE_EN adds an 11-entry readable store of
// the emitted round keys (ports rd_idx / rd_key).
//
//   state | meaning
//   IDLE  | waiting for a round-10 key, in_ready high
//   RUN   | presenting rk_out for rk_idx, stepping back on each accepted beat
module aes_inv_key_schedule
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_key_t   key_in,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_key_t   rk_out,
  output logic [3:0] rk_idx,
  output logic       rk_last
`ifdef AES_INV_KEY_STORE_EN
  ,
  input  logic [3:0] rd_idx,
  output aes_key_t   rd_key
`endif
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_inv_key_schedule supports only NUM_ROUNDS == 10");
  end

  state_t    state, state_next;
  aes_word_t wa, wb, wc, wd;
  aes_word_t na, nb, nc, nd;
  aes_word_t rot, sub;
  logic [7:0] rcon_byte;
  aes_key_t  next_key;

  // One backward step of the schedule, purely from the rk_out register.
  always_comb begin
    {wa, wb, wc, wd} = rk_out;
    nd = wd ^ wc;
    nc = wc ^ wb;
    nb = wb ^ wa;
    rot = rot_word(nd);
    rcon_byte = 8'h00;
    if (rk_idx >= 4'd1 && rk_idx <= 4'd10) rcon_byte = RCON[rk_idx];
    na = wa ^ sub ^ {rcon_byte, 24'h0};
    next_key = {na, nb, nc, nd};
  end

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.x(rot[8*i +: 8]), .y(sub[8*i +: 8]));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        if (out_ready && rk_idx == 4'd0) state_next = IDLE;
      end
    endcase
  end

  // Round key register: load on accept, step back on each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_out <= '0;
      rk_idx <= '0;
    end else if (state == IDLE && in_valid) begin
      rk_out <= key_in;
      rk_idx <= 4'(NUM_ROUNDS);
    end else if (state == RUN && out_ready && rk_idx != 4'd0) begin
      rk_out <= next_key;
      rk_idx <= rk_idx - 4'd1;
    end
  end

  assign rk_last = out_valid && (rk_idx == 4'd0);

`ifdef AES_INV_KEY_STORE_EN
  aes_key_t store [0:10];

  // Capture every presented beat; rewriting a held beat stores the same value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) store[i] <= '0;
    end else if (out_valid) begin
      store[rk_idx] <= rk_out;
    end
  end

  // Combinational read port, zero outside the valid round range.
  always_comb begin
    rd_key = '0;
    if (rd_idx <= 4'd10) rd_key = store[rd_idx];
  end
`endif

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule: FIPS-197 vector, backpressure,
// ignored in_valid during RUN, mid-sequence reset, back-to-back keys, random keys.
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_last;
`ifdef AES_INV_KEY_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif

  aes_inv_key_schedule dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .key_in(key_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .rk_out(rk_out), .rk_idx(rk_idx), .rk_last(rk_last)
`ifdef AES_INV_KEY_STORE_EN
    , .rd_idx(rd_idx), .rd_key(rd_key)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox_ref [256];
  logic [7:0]   rcon_ref [1:10];
  logic [127:0] exp_rk   [0:10];
  logic [127:0] got      [0:10];

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v};
    logic [15:0] s = d << n;
    return s[15:8];
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_tables();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h00;
      for (int u = 1; u < 256; u++)
        if (v != 0 && gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
      sbox_ref[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rcon_ref[1] = 8'h01;
    for (int r = 2; r <= 10; r++) rcon_ref[r] = xtime(rcon_ref[r-1]);
  endtask

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [7:0] b0 = w[31:24];
    logic [7:0] b1 = w[23:16];
    logic [7:0] b2 = w[15:8];
    logic [7:0] b3 = w[7:0];
    return {sbox_ref[b1], sbox_ref[b2], sbox_ref[b3], sbox_ref[b0]};
  endfunction

  // Inverts the FIPS word recurrence w[i+4] = w[i] ^ f(w[i+3]) starting from round 10.
  task automatic calc_ref(input logic [127:0] k10);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int j = 0; j < 4; j++) w[40+j] = k10[127-32*j -: 32];
    for (int i = 39; i >= 0; i--) begin
      t = w[i+3];
      if (i % 4 == 0) t = sub_rot(t) ^ {rcon_ref[i/4+1], 24'h0};
      w[i] = w[i+4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_rk_out",    rk_out,          128'(0));
    chk("rst_rk_idx",    128'(rk_idx),    128'(0));
    chk("rst_rk_last",   128'(rk_last),   128'(0));
  endtask

  // Feed one key and consume its 11 beats; entered and left at a sample point.
  task automatic stream_key(input logic [127:0] key, input int stall_at, input int stall_len,
                            input bit rand_bp, input bit hold_next, input logic [127:0] key2);
    int e = 10;
    int stalls = 0;
    int budget = 200;
    bit rdy;
    calc_ref(key);
    chk("idle_in_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    key_in = key;
    out_ready = 1'b0;
    @(posedge clk); #1;
    if (hold_next) key_in = key2;
    else begin
      in_valid = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
    end
    while (e >= 0 && budget > 0) begin
      budget--;
      chk("out_valid", 128'(out_valid), 128'(1));
      chk("run_in_ready", 128'(in_ready), 128'(0));
      chk("rk_idx", 128'(rk_idx), 128'(e));
      chk("rk_out", rk_out, exp_rk[e]);
      chk("rk_last", 128'(rk_last), 128'(e == 0));
      got[e] = rk_out;
      if (e == stall_at && stalls < stall_len) begin
        rdy = 1'b0;
        stalls++;
      end else if (rand_bp) rdy = ($urandom_range(0, 2) != 0);
      else rdy = 1'b1;
      out_ready = rdy;
      @(posedge clk); #1;
      if (rdy) e--;
    end
    if (e >= 0) chk("beat_timeout", 128'(e), 128'(-1));
    out_ready = 1'b0;
    chk("done_out_valid", 128'(out_valid), 128'(0));
    chk("done_in_ready", 128'(in_ready), 128'(1));
    chk("done_rk_last", 128'(rk_last), 128'(0));
  endtask

  task automatic reset_mid(input logic [127:0] key);
    int budget = 50;
    in_valid = 1'b1;
    key_in = key;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (rk_idx != 4'd4 && budget > 0) begin
      budget--;
      @(posedge clk); #1;
    end
    chk("mid_idx", 128'(rk_idx), 128'(4));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    chk_reset_vals();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ka, kb;
    build_tables();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    key_in = '0;
`ifdef AES_INV_KEY_STORE_EN
    rd_idx = 4'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
`ifdef AES_INV_KEY_STORE_EN
    rd_idx = 4'd10; #1;
    chk("store_reset", rd_key, 128'(0));
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 A.1 vector, no backpressure
    stream_key(FIPS_K10, -1, 0, 1'b0, 1'b0, '0);
    chk("fips_k10", got[10], FIPS_K10);
    chk("fips_k9",  got[9],  FIPS_K9);
    chk("fips_k1",  got[1],  FIPS_K1);
    chk("fips_k0",  got[0],  FIPS_K0);
`ifdef AES_INV_KEY_STORE_EN
    for (int i = 0; i <= 10; i++) begin
      rd_idx = 4'(i); #1;
      chk("store_rd", rd_key, exp_rk[i]);
    end
    rd_idx = 4'd15; #1;
    chk("store_rd15", rd_key, 128'(0));
`endif

    // Three-cycle stall at idx 7
    stream_key({$urandom, $urandom, $urandom, $urandom}, 7, 3, 1'b0, 1'b0, '0);

    // in_valid held through RUN with a different key; second key follows immediately
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    stream_key(ka, -1, 0, 1'b0, 1'b1, kb);
    stream_key(kb, -1, 0, 1'b0, 1'b0, '0);

    // Reset at idx 4, then a clean restart
    reset_mid({$urandom, $urandom, $urandom, $urandom});
    stream_key({$urandom, $urandom, $urandom, $urandom}, -1, 0, 1'b0, 1'b0, '0);

    // Back-to-back: all-zero round-10 key then the FIPS key
    stream_key('0, -1, 0, 1'b0, 1'b0, '0);
    stream_key(FIPS_K10, -1, 0, 1'b0, 1'b0, '0);
    chk("b2b_fips_k0", got[0], FIPS_K0);

    // Random keys with random backpressure
    for (int n = 0; n < 5; n++)
      stream_key({$urandom, $urandom, $urandom, $urandom}, -1, 0, 1'b1, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
